operand_latch: RTL and testbench

OPERAND_LATCH -- requirements
Module: operand_latch

---
 rtl/operand_latch_pkg.sv | 14 +
 rtl/index_adder.sv | 21 ++
 rtl/operand_latch.sv | 103 ++++++++++
 tb/tb_operand_latch.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_latch_pkg.sv
// Shared types and constants for the operand latch.
// Holds the FSM state type, byte width and the largest legal byte count.
package operand_latch_pkg;

  localparam int BYTE_W = 8;
  localparam int MAX_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

endpackage

// File: rtl/index_adder.sv
// Effective-address adder: operand plus zero-extended 8-bit index.
// Ports: operand/index in, ea (wraps at W bits) and page_cross (bit 7 carry) out.
`ifdef OPERAND_LATCH_INDEX_EN
module index_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] operand,
  input  logic [7:0]   index,
  output logic [W-1:0] ea,
  output logic         page_cross
);

  logic [8:0] low_sum;

  // Low byte summed separately so the bit-7 carry exists even when W == 8.
  assign low_sum    = {1'b0, operand[7:0]} + {1'b0, index};
  assign page_cross = low_sum[8];
  assign ea         = operand + W'(index);

endmodule
`endif

// File: rtl/operand_latch.sv
// Byte-serial operand capture with length check, error flag and indexed EA.
// Ports: fclk/resb, start/len/load/db_in/clear/index in; operand, db_out,
// count, busy, full, err, ea, page_cross out. Macro OPERAND_LATCH_INDEX_EN
// enables the index adder; otherwise ea = operand and page_cross = 0.
module operand_latch
  import operand_latch_pkg::*;
#(
  parameter  int NUM_BYTES = 2,
  localparam int LW = $clog2(NUM_BYTES + 1),
  localparam int OW = BYTE_W * NUM_BYTES
) (
  input  logic          fclk,
  input  logic          resb,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          load,
  input  logic [7:0]    db_in,
  input  logic          clear,
  input  logic [7:0]    index,
  output logic [OW-1:0] operand,
  output logic [7:0]    db_out,
  output logic [LW-1:0] count,
  output logic          busy,
  output logic          full,
  output logic          err,
  output logic [OW-1:0] ea,
  output logic          page_cross
);

  state_t        state;
  logic [LW-1:0] len_q;
  logic [LW-1:0] count_nx;
  logic          len_ok;

  assign len_ok   = (len != '0) && (len <= LW'(NUM_BYTES));
  assign count_nx = count + LW'(1);

  always_ff @(posedge fclk or negedge resb) begin
    if (!resb) begin
      state   <= IDLE;
      operand <= '0;
      count   <= '0;
      len_q   <= '0;
      err     <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      operand <= '0;
      count   <= '0;
      len_q   <= '0;
      err     <= 1'b0;
    end else if (start && len_ok) begin
      len_q <= len;
      if (load) begin
        operand <= OW'(db_in);
        count   <= LW'(1);
        state   <= (len == LW'(1)) ? FULL : COLLECT;
      end else begin
        operand <= '0;
        count   <= '0;
        state   <= COLLECT;
      end
    end else begin
      // A rejected start only flags; a same-cycle load is handled normally.
      if (start)
        err <= 1'b1;
      if (load) begin
        unique case (1'b1)
          state == COLLECT: begin
            for (int i = 0; i < NUM_BYTES; i++)
              if (count == LW'(i))
                operand[BYTE_W*i +: BYTE_W] <= db_in;
            count <= count_nx;
            if (count_nx == len_q)
              state <= FULL;
          end
          default: err <= 1'b1;
        endcase
      end
    end
  end

  assign busy   = (state == COLLECT);
  assign full   = (state == FULL);
  assign db_out = operand[7:0];

`ifdef OPERAND_LATCH_INDEX_EN
  index_adder #(
    .W (OW)
  ) u_index_adder (
    .operand    (operand),
    .index      (index),
    .ea         (ea),
    .page_cross (page_cross)
  );
`else
  logic unused_index;

  assign unused_index = ^index;
  assign ea           = operand;
  assign page_cross   = 1'b0;
`endif

endmodule

// File: tb/tb_operand_latch.sv
// Directed self-checking bench for operand_latch with NUM_BYTES = 2.
// Index checks follow whichever OPERAND_LATCH_INDEX_EN build is compiled.
module tb_operand_latch;

  localparam int NB = 2;
  localparam int LW = $clog2(NB + 1);
  localparam int OW = 8 * NB;

  logic          fclk = 1'b0;
  logic          resb;
  logic          start;
  logic [LW-1:0] len;
  logic          load;
  logic [7:0]    db_in;
  logic          clear;
  logic [7:0]    index;
  logic [OW-1:0] operand;
  logic [7:0]    db_out;
  logic [LW-1:0] count;
  logic          busy;
  logic          full;
  logic          err;
  logic [OW-1:0] ea;
  logic          page_cross;

  int passed = 0;
  int total  = 0;

  operand_latch #(
    .NUM_BYTES (NB)
  ) dut (
    .fclk       (fclk),
    .resb       (resb),
    .start      (start),
    .len        (len),
    .load       (load),
    .db_in      (db_in),
    .clear      (clear),
    .index      (index),
    .operand    (operand),
    .db_out     (db_out),
    .count      (count),
    .busy       (busy),
    .full       (full),
    .err        (err),
    .ea         (ea),
    .page_cross (page_cross)
  );

  always #5 fclk = ~fclk;

  task automatic step();
    @(posedge fclk);
    #1;
    start = 1'b0;
    load  = 1'b0;
    clear = 1'b0;
  endtask

  task automatic do_start(input logic [LW-1:0] l, input logic ld,
                          input logic [7:0] d);
    start = 1'b1;
    len   = l;
    load  = ld;
    db_in = d;
    step();
  endtask

  task automatic do_load(input logic [7:0] d);
    load  = 1'b1;
    db_in = d;
    step();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
  endtask

  task automatic test_reset();
    resb = 1'b0;
    #12;
    total++;
    if ({operand, count, busy, full, err, db_out, ea, page_cross} !== '0)
      $display("FAIL reset_outputs: op=%h cnt=%0d busy=%b full=%b err=%b ea=%h pc=%b want all 0",
               operand, count, busy, full, err, ea, page_cross);
    else passed++;
    @(negedge fclk);
    resb = 1'b1;
    step();
  endtask

  task automatic test_two_byte();
    do_start(2'd2, 1'b0, 8'h00);
    total++;
    if (busy !== 1'b1 || count !== 2'd0 || full !== 1'b0)
      $display("FAIL start_collect: busy=%b cnt=%0d full=%b want 1 0 0", busy, count, full);
    else passed++;
    do_load(8'h34);
    total++;
    if (operand !== 16'h0034 || count !== 2'd1 || busy !== 1'b1 || full !== 1'b0)
      $display("FAIL first_byte: op=%h cnt=%0d busy=%b full=%b want 0034 1 1 0",
               operand, count, busy, full);
    else passed++;
    do_load(8'h12);
    total++;
    if (operand !== 16'h1234 || count !== 2'd2 || full !== 1'b1 ||
        busy !== 1'b0 || err !== 1'b0)
      $display("FAIL second_byte: op=%h cnt=%0d full=%b busy=%b err=%b want 1234 2 1 0 0",
               operand, count, full, busy, err);
    else passed++;
    total++;
    if (db_out !== 8'h34)
      $display("FAIL db_out: got %h want 34", db_out);
    else passed++;
  endtask

  task automatic test_index();
`ifdef OPERAND_LATCH_INDEX_EN
    do_start(2'd2, 1'b1, 8'hF0);
    do_load(8'h12);
    index = 8'h20;
    #1;
    total++;
    if (operand !== 16'h12F0 || ea !== 16'h1310 || page_cross !== 1'b1)
      $display("FAIL ea_carry: op=%h ea=%h pc=%b want 12F0 1310 1", operand, ea, page_cross);
    else passed++;
    index = 8'h05;
    #1;
    total++;
    if (ea !== 16'h12F5 || page_cross !== 1'b0)
      $display("FAIL ea_nocarry: ea=%h pc=%b want 12F5 0", ea, page_cross);
    else passed++;
`else
    do_start(2'd1, 1'b1, 8'hFF);
    index = 8'hFF;
    #1;
    total++;
    if (operand !== 16'h00FF || ea !== 16'h00FF || page_cross !== 1'b0)
      $display("FAIL ea_passthru: op=%h ea=%h pc=%b want 00FF 00FF 0", operand, ea, page_cross);
    else passed++;
    index = 8'h05;
    #1;
    total++;
    if (ea !== 16'h00FF || page_cross !== 1'b0)
      $display("FAIL ea_ignore_idx: ea=%h pc=%b want 00FF 0", ea, page_cross);
    else passed++;
`endif
    index = 8'h00;
  endtask

  task automatic test_start_load_same();
    do_start(2'd1, 1'b1, 8'hA9);
    total++;
    if (operand !== 16'h00A9 || full !== 1'b1 || busy !== 1'b0 || count !== 2'd1)
      $display("FAIL start_load_len1: op=%h full=%b busy=%b cnt=%0d want 00A9 1 0 1",
               operand, full, busy, count);
    else passed++;
  endtask

  task automatic test_full_errors();
    do_load(8'h77);
    total++;
    if (operand !== 16'h00A9 || err !== 1'b1 || full !== 1'b1)
      $display("FAIL load_in_full: op=%h err=%b full=%b want 00A9 1 1", operand, err, full);
    else passed++;
    do_start(2'd3, 1'b0, 8'h00);
    total++;
    if (err !== 1'b1 || full !== 1'b1 || operand !== 16'h00A9 || count !== 2'd1)
      $display("FAIL bad_len_start: err=%b full=%b op=%h cnt=%0d want 1 1 00A9 1",
               err, full, operand, count);
    else passed++;
    do_clear();
    total++;
    if (err !== 1'b0 || busy !== 1'b0 || full !== 1'b0 ||
        operand !== 16'h0000 || count !== 2'd0)
      $display("FAIL clear: err=%b busy=%b full=%b op=%h cnt=%0d want 0 0 0 0000 0",
               err, busy, full, operand, count);
    else passed++;
  endtask

  task automatic test_idle_errors();
    do_start(2'd0, 1'b0, 8'h00);
    total++;
    if (err !== 1'b1 || busy !== 1'b0 || full !== 1'b0)
      $display("FAIL zero_len: err=%b busy=%b full=%b want 1 0 0", err, busy, full);
    else passed++;
    do_clear();
    do_load(8'h5A);
    total++;
    if (err !== 1'b1 || operand !== 16'h0000 || count !== 2'd0)
      $display("FAIL load_in_idle: err=%b op=%h cnt=%0d want 1 0000 0", err, operand, count);
    else passed++;
    do_start(2'd2, 1'b0, 8'h00);
    total++;
    if (err !== 1'b1 || busy !== 1'b1)
      $display("FAIL err_sticky: err=%b busy=%b want 1 1", err, busy);
    else passed++;
    do_clear();
  endtask

  task automatic test_zero_extend_restart();
    do_start(2'd1, 1'b0, 8'h00);
    do_load(8'hC3);
    total++;
    if (operand !== 16'h00C3 || full !== 1'b1 || count !== 2'd1)
      $display("FAIL len1_zext: op=%h full=%b cnt=%0d want 00C3 1 1", operand, full, count);
    else passed++;
    do_start(2'd2, 1'b0, 8'h00);
    do_load(8'h11);
    do_start(2'd2, 1'b0, 8'h00);
    total++;
    if (operand !== 16'h0000 || count !== 2'd0 || busy !== 1'b1)
      $display("FAIL restart: op=%h cnt=%0d busy=%b want 0000 0 1", operand, count, busy);
    else passed++;
    start = 1'b1;
    len   = 2'd2;
    clear = 1'b1;
    step();
    total++;
    if (busy !== 1'b0 || full !== 1'b0 || count !== 2'd0)
      $display("FAIL clear_priority: busy=%b full=%b cnt=%0d want 0 0 0", busy, full, count);
    else passed++;
  endtask

  task automatic test_async_reset();
    do_start(2'd2, 1'b0, 8'h00);
    do_load(8'h55);
    total++;
    if (operand !== 16'h0055 || count !== 2'd1 || busy !== 1'b1)
      $display("FAIL pre_reset: op=%h cnt=%0d busy=%b want 0055 1 1", operand, count, busy);
    else passed++;
    #2;
    resb = 1'b0;
    #1;
    total++;
    if (operand !== 16'h0000 || count !== 2'd0 || busy !== 1'b0 || full !== 1'b0)
      $display("FAIL async_reset: op=%h cnt=%0d busy=%b full=%b want 0000 0 0 0",
               operand, count, busy, full);
    else passed++;
    @(negedge fclk);
    resb = 1'b1;
    step();
  endtask

  initial begin
    resb  = 1'b0;
    start = 1'b0;
    len   = '0;
    load  = 1'b0;
    db_in = 8'h00;
    clear = 1'b0;
    index = 8'h00;
    test_reset();
    test_two_byte();
    test_index();
    test_start_load_same();
    test_full_errors();
    test_idle_errors();
    test_zero_extend_restart();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
